// File: rtl/eth_frame_tx_if.sv
// Packer-side request/status and RMII transmit pins of eth_frame_tx.
// Latency/backpressure: first dibit one cycle after start; no backpressure, start ignored while busy.
interface eth_frame_tx_if #(
    parameter int PAYLOAD_BYTES = 6
);
    logic                       start;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic                       busy;
    logic                       done;
    logic [15:0]                frame_count;
    logic [1:0]                 eth_txd;
    logic                       eth_txen;

    modport master (
        output start, payload,
        input  busy, done, frame_count, eth_txd, eth_txen
    );

    modport slave (
        input  start, payload,
        output busy, done, frame_count, eth_txd, eth_txen
    );
endinterface

// File: rtl/eth_frame_tx.sv
// RMII Ethernet II frame transmitter: preamble, SFD, header, payload, pad, CRC-32 FCS, IFG.
// Latency: first preamble dibit one cycle after start; no backpressure, start ignored while busy.
module eth_frame_tx #(
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [47:0] DEST_MAC      = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC       = 48'hAB_CD_EF_AB_CD_EF,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int          IFG_BYTES     = 12
) (
    input  logic          eth_clk,
    input  logic          eth_rstn,
    eth_frame_tx_if.slave tx
);

    localparam int           PAD_BYTES = (PAYLOAD_BYTES < 46) ? (46 - PAYLOAD_BYTES) : 0;
    localparam logic [111:0] HDR       = {DEST_MAC, SRC_MAC, ETHERTYPE};

    typedef logic [10:0] idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_HEADER,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    function automatic idx_t last_byte(input state_t s);
        idx_t r;
        r = '0;
        case (s)
            S_PREAMBLE: r = idx_t'(6);
            S_SFD:      r = idx_t'(0);
            S_HEADER:   r = idx_t'(13);
            S_PAYLOAD:  r = idx_t'(PAYLOAD_BYTES - 1);
            S_PAD:      r = (PAD_BYTES > 0) ? idx_t'(PAD_BYTES - 1) : idx_t'(0);
            S_FCS:      r = idx_t'(3);
            S_IFG:      r = idx_t'(IFG_BYTES - 1);
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic state_t next_of(input state_t s);
        state_t r;
        r = S_IDLE;
        case (s)
            S_PREAMBLE: r = S_SFD;
            S_SFD:      r = S_HEADER;
            S_HEADER:   r = S_PAYLOAD;
            S_PAYLOAD:  r = (PAD_BYTES > 0) ? S_PAD : S_FCS;
            S_PAD:      r = S_FCS;
            S_FCS:      r = S_IFG;
            default:    r = S_IDLE;
        endcase
        return r;
    endfunction

    // Reflected CRC-32, one dibit, bit 0 first (matches wire order).
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    state_t                     state_q, state_d;
    logic [1:0]                 dib_q, dib_d;
    idx_t                       byte_q, byte_d;
    logic [8*PAYLOAD_BYTES-1:0] pay_q, pay_d;
    logic [31:0]                crc_q, crc_d;
    logic [1:0]                 txd_q, txd_d;
    logic                       txen_q, txen_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [15:0]                cnt_q, cnt_d;

    logic [7:0]                 cur_byte;
    logic [7:0]                 cur_sh;
    logic [111:0]               hdr_sh;
    logic [8*PAYLOAD_BYTES-1:0] pay_sh;
    logic [31:0]                fcs_sh;

    // Outputs are registered, so they are computed from the position the
    // counters move to this cycle (state_d/byte_d/dib_d).
    always_comb begin
        state_d  = state_q;
        dib_d    = dib_q;
        byte_d   = byte_q;
        pay_d    = pay_q;
        crc_d    = crc_q;
        cur_byte = 8'h00;
        cur_sh   = 8'h00;
        hdr_sh   = '0;
        pay_sh   = '0;
        fcs_sh   = '0;
        txd_d    = 2'b00;
        txen_d   = 1'b0;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (tx.start) begin
                state_d = S_PREAMBLE;
                dib_d   = 2'd0;
                byte_d  = '0;
                pay_d   = tx.payload;
                crc_d   = 32'hFFFF_FFFF;
            end
        end else if (dib_q == 2'd3) begin
            dib_d = 2'd0;
            if (byte_q == last_byte(state_q)) begin
                state_d = next_of(state_q);
                byte_d  = '0;
            end else begin
                byte_d = byte_q + 1'b1;
            end
        end else begin
            dib_d = dib_q + 2'd1;
        end

        case (state_d)
            S_PREAMBLE: cur_byte = 8'h55;
            S_SFD:      cur_byte = 8'hD5;
            S_HEADER: begin
                hdr_sh   = HDR >> (8 * (13 - int'(byte_d)));
                cur_byte = hdr_sh[7:0];
            end
            S_PAYLOAD: begin
                pay_sh   = pay_q >> (8 * (PAYLOAD_BYTES - 1 - int'(byte_d)));
                cur_byte = pay_sh[7:0];
            end
            S_FCS: begin
                fcs_sh   = (~crc_q) >> (8 * int'(byte_d[1:0]));
                cur_byte = fcs_sh[7:0];
            end
            default:    cur_byte = 8'h00;
        endcase

        txen_d = (state_d != S_IDLE) && (state_d != S_IFG);
        cur_sh = cur_byte >> (2 * int'(dib_d));
        txd_d  = txen_d ? cur_sh[1:0] : 2'b00;

        // crc_q always includes every covered dibit already loaded into txd_q.
        if (state_d inside {S_HEADER, S_PAYLOAD, S_PAD}) begin
            crc_d = crc_dibit(crc_q, txd_d);
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_IFG) && (dib_d == 2'd3) && (byte_d == last_byte(S_IFG));
        cnt_d  = cnt_q + {15'd0, done_d};
    end

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            state_q <= S_IDLE;
            dib_q   <= 2'd0;
            byte_q  <= '0;
            pay_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            txd_q   <= 2'b00;
            txen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            dib_q   <= dib_d;
            byte_q  <= byte_d;
            pay_q   <= pay_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx.eth_txd     = txd_q;
    assign tx.eth_txen    = txen_q;
    assign tx.busy        = busy_q;
    assign tx.done        = done_q;
    assign tx.frame_count = cnt_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx: stimulus pushes expected frame bytes, a monitor reassembles dibits and compares.
`timescale 1ns/1ps
module tb_eth_frame_tx;

    logic clk = 1'b0;
    logic rstn6;
    logic rstn60;
    always #10 clk = ~clk;

    eth_frame_tx_if #(.PAYLOAD_BYTES(6))  if6  ();
    eth_frame_tx_if #(.PAYLOAD_BYTES(60)) if60 ();

    eth_frame_tx #(.PAYLOAD_BYTES(6))  dut6  (.eth_clk(clk), .eth_rstn(rstn6),  .tx(if6));
    eth_frame_tx #(.PAYLOAD_BYTES(60)) dut60 (.eth_clk(clk), .eth_rstn(rstn60), .tx(if60));

    int checks   = 0;
    int failures = 0;
    int txd_idle_bad = 0;

    logic [7:0] hdr_b [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'hAB, 8'hCD, 8'hEF, 8'hAB, 8'hCD, 8'hEF,
                               8'h88, 8'hB5};
    logic [7:0] pay_b [60];

    logic [7:0] exp6_q[$];
    logic [7:0] exp60_q[$];
    int         elen6_q[$];
    int         elen60_q[$];
    logic [1:0] cap6[$];
    logic [1:0] cap60[$];
    logic [1:0] cur_dib[$];
    logic [7:0] cur_exp[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_frame(input int d, input int plen);
        logic [7:0]  fr[$];
        logic [31:0] c;
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 14; i++) fr.push_back(hdr_b[i]);
        for (int i = 0; i < plen; i++) fr.push_back(pay_b[i]);
        for (int i = plen; i < 46; i++) fr.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < fr.size(); i++) c = crc_byte(c, fr[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
        if (d == 0) begin
            foreach (fr[i]) exp6_q.push_back(fr[i]);
            elen6_q.push_back(fr.size());
        end else begin
            foreach (fr[i]) exp60_q.push_back(fr[i]);
            elen60_q.push_back(fr.size());
        end
    endtask

    task automatic check_frame(input string nm);
        logic [7:0]  got[$];
        logic [31:0] c;
        int          nb;
        int          bad;
        nb = cur_dib.size() / 4;
        chk({nm, " txen cycles"}, cur_dib.size(), cur_exp.size() * 4);
        bad = 0;
        for (int i = 0; i < 32 && i < cur_dib.size(); i++)
            if (cur_dib[i] !== ((i == 31) ? 2'b11 : 2'b01)) bad++;
        chk({nm, " preamble/SFD bad dibits"}, bad, 0);
        for (int b = 0; b < nb; b++)
            got.push_back({cur_dib[4*b+3], cur_dib[4*b+2], cur_dib[4*b+1], cur_dib[4*b]});
        bad = -1;
        for (int b = 0; b < nb && b < cur_exp.size(); b++)
            if (bad < 0 && got[b] !== cur_exp[b]) bad = b;
        chk({nm, " first wrong byte index"}, bad, -1);
        c = 32'hFFFF_FFFF;
        for (int b = 8; b < nb; b++) c = crc_byte(c, got[b]);
        chk({nm, " CRC residue"}, c, 32'hDEBB20E3);
    endtask

    task automatic finish_frame(input int d);
        int n;
        cur_exp.delete();
        if (d == 0) begin
            chk("dut6 frame expected", elen6_q.size() > 0, 1);
            if (elen6_q.size() > 0) begin
                n = elen6_q.pop_front();
                for (int i = 0; i < n; i++) cur_exp.push_back(exp6_q.pop_front());
                check_frame("dut6");
            end
        end else begin
            chk("dut60 frame expected", elen60_q.size() > 0, 1);
            if (elen60_q.size() > 0) begin
                n = elen60_q.pop_front();
                for (int i = 0; i < n; i++) cur_exp.push_back(exp60_q.pop_front());
                check_frame("dut60");
            end
        end
    endtask

    // Monitor: capture dibits while txen is high; a frame ends when txen drops.
    always @(negedge clk) begin
        if (rstn6 && !if6.eth_txen && if6.eth_txd != 2'b00) txd_idle_bad++;
        if (!rstn6) cap6.delete();
        else if (if6.eth_txen) cap6.push_back(if6.eth_txd);
        else if (cap6.size() != 0) begin
            cur_dib = cap6;
            cap6.delete();
            finish_frame(0);
        end
        if (!rstn60) cap60.delete();
        else if (if60.eth_txen) cap60.push_back(if60.eth_txd);
        else if (cap60.size() != 0) begin
            cur_dib = cap60;
            cap60.delete();
            finish_frame(1);
        end
    end

    // One frame on dut6; optional stray start pulses at frame cycles stray_a/stray_b.
    task automatic run6(input logic [47:0] pay, input int stray_a, input int stray_b,
                        output int busy_cyc, output int done_cyc, output int done_n);
        for (int i = 0; i < 6; i++) pay_b[i] = pay[8*(5-i) +: 8];
        push_frame(0, 6);
        if6.payload = pay;
        if6.start   = 1'b1;
        @(negedge clk);
        if6.start = 1'b0;
        chk("txen one cycle after accept", if6.eth_txen, 1);
        busy_cyc = 0;
        done_cyc = 0;
        done_n   = 0;
        for (int k = 1; k <= 2000 && if6.busy; k++) begin
            busy_cyc++;
            if (if6.done) begin
                done_n++;
                done_cyc = k;
            end
            if (k == stray_a || k == stray_b) begin
                if6.start   = 1'b1;
                if6.payload = ~pay;
            end else begin
                if6.start = 1'b0;
            end
            @(negedge clk);
        end
        if6.start = 1'b0;
        chk("busy falls within bound", if6.busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, dc, dn, zero_run, seen_tx;
        int gaps[$];

        rstn6 = 1'b0;
        rstn60 = 1'b0;
        if6.start = 1'b0;
        if6.payload = '0;
        if60.start = 1'b0;
        if60.payload = '0;
        repeat (3) @(negedge clk);
        chk("reset txen", if6.eth_txen, 0);
        chk("reset txd", if6.eth_txd, 0);
        chk("reset busy", if6.busy, 0);
        chk("reset done", if6.done, 0);
        chk("reset frame_count", if6.frame_count, 0);
        chk("reset frame_count dut60", if60.frame_count, 0);
        rstn6 = 1'b1;
        rstn60 = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 6-byte frame.
        run6(48'h0102_0304_0506, -1, -1, bc, dc, dn);
        chk("t1 busy cycles", bc, 336);
        chk("t1 done cycle", dc, 336);
        chk("t1 done pulses", dn, 1);
        chk("t1 frame_count", if6.frame_count, 1);
        repeat (3) @(negedge clk);

        // 60-byte build, no pad.
        for (int i = 0; i < 60; i++) begin
            pay_b[i] = 8'(i);
            if60.payload[8*(59-i) +: 8] = 8'(i);
        end
        push_frame(1, 60);
        if60.start = 1'b1;
        @(negedge clk);
        if60.start = 1'b0;
        chk("t2 busy after accept", if60.busy, 1);
        for (int k = 0; k < 2000 && if60.busy; k++) @(negedge clk);
        chk("t2 busy falls within bound", if60.busy, 0);
        chk("t2 frame_count", if60.frame_count, 1);

        // Stray starts mid-frame and in the IFG are ignored.
        run6(48'hC0FF_EE12_3456, 100, 300, bc, dc, dn);
        chk("t3 busy cycles", bc, 336);
        chk("t3 done pulses", dn, 1);
        chk("t3 frame_count", if6.frame_count, 2);
        repeat (60) @(negedge clk);
        chk("t3 no extra frame busy", if6.busy, 0);
        chk("t3 frame_count stable", if6.frame_count, 2);

        // Start held high for three back-to-back frames.
        rstn6 = 1'b0;
        @(negedge clk);
        rstn6 = 1'b1;
        chk("t4 frame_count cleared", if6.frame_count, 0);
        for (int i = 0; i < 6; i++) pay_b[i] = 8'h11 * (i + 1);
        for (int f = 0; f < 3; f++) push_frame(0, 6);
        if6.payload = 48'h1122_3344_5566;
        if6.start   = 1'b1;
        zero_run = 0;
        seen_tx  = 0;
        dn       = 0;
        for (int k = 0; k < 3000 && dn < 3; k++) begin
            @(negedge clk);
            if (if6.eth_txen) begin
                if (seen_tx != 0 && zero_run > 0) gaps.push_back(zero_run);
                seen_tx  = 1;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            if (if6.done) begin
                dn++;
                if (dn == 3) if6.start = 1'b0;
            end
        end
        if6.start = 1'b0;
        chk("t4 done pulses", dn, 3);
        chk("t4 gap count", gaps.size(), 2);
        foreach (gaps[i]) chk("t4 idle gap cycles", gaps[i], 49);
        repeat (5) @(negedge clk);
        chk("t4 frame_count", if6.frame_count, 3);
        chk("t4 busy after", if6.busy, 0);

        // Reset mid-frame at frame cycle 150.
        for (int i = 0; i < 6; i++) pay_b[i] = 8'hA0 + 8'(i);
        if6.payload = 48'hA0A1_A2A3_A4A5;
        if6.start   = 1'b1;
        @(negedge clk);
        if6.start = 1'b0;
        dn = 0;
        for (int k = 1; k < 150; k++) begin
            if (if6.done) dn++;
            @(negedge clk);
        end
        chk("t5 txen before reset", if6.eth_txen, 1);
        @(posedge clk);
        #1 rstn6 = 1'b0;
        #1;
        chk("t5 txen async drop", if6.eth_txen, 0);
        chk("t5 busy async drop", if6.busy, 0);
        chk("t5 frame_count after reset", if6.frame_count, 0);
        chk("t5 no done before reset", dn, 0);
        repeat (2) @(negedge clk);
        rstn6 = 1'b1;
        @(negedge clk);
        run6(48'h5A5A_0F0F_F00D, -1, -1, bc, dc, dn);
        chk("t5 busy cycles", bc, 336);
        chk("t5 frame_count", if6.frame_count, 1);

        repeat (10) @(negedge clk);
        chk("dut6 scoreboard drained", elen6_q.size(), 0);
        chk("dut60 scoreboard drained", elen60_q.size(), 0);
        chk("txd zero while txen low", txd_idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
